amber_wb_responder: RTL and testbench
=====================================

AMBER_WB_RESPONDER -- requirements
Module: amber_wb_responder

Interface
REQ-001 Parameter: DATA_W, 128, Wishbone data width in bits; byte-select width is DATA_W/8.
REQ-002 Parameter: WAIT_CYCLES, 2, wait states inserted between request acceptance and response (0 legal).
REQ-003 Parameter: ERR_BASE, 32'hF000_0000, lowest address that responds with error.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 i_wb_adr  in  32  master byte address.
REQ-007 i_wb_sel  in  DATA_W/8  master byte-lane select.
REQ-008 i_wb_we  in  1  master write enable (1 = write).
REQ-009 i_wb_dat  in  DATA_W  master write data.
REQ-010 i_wb_cyc  in  1  master bus cycle valid.
REQ-011 i_wb_stb  in  1  master strobe.
REQ-012 i_rnd  in  DATA_W  free-running random word from the random number generator.
REQ-013 o_wb_dat  out  DATA_W  read data to master.
REQ-014 o_wb_ack  out  1  normal termination, one-cycle pulse.
REQ-015 o_wb_err  out  1  error termination, one-cycle pulse.
REQ-016 o_signature  out  DATA_W  accumulated write signature; keeps write datapath observable.
REQ-017 o_busy  out  1  high whenever the FSM is not IDLE.

Function
REQ-018 FSM states: IDLE, WAIT, RESP; all outputs registered except o_busy (decoded from state).
REQ-019 IDLE: on rising edge with i_wb_cyc & i_wb_stb high, latch adr, we, sel, dat; go to WAIT if WAIT_CYCLES>0, else RESP.
REQ-020 WAIT: wait counter (width clog2(WAIT_CYCLES+1)) loads WAIT_CYCLES at acceptance, decrements each cycle; go to RESP on the edge where counter reaches 1.
REQ-021 Latency: request sampled at edge N -> ack/err high during the cycle after edge N+1+WAIT_CYCLES, for exactly one cycle.
REQ-022 RESP: assert exactly one of o_wb_ack / o_wb_err for one cycle, then return to IDLE; new requests are not sampled in RESP (minimum one idle cycle between responses).
REQ-023 Error decode: latched address >= ERR_BASE (unsigned) -> o_wb_err, no ack, no signature update, o_wb_dat unchanged.
REQ-024 Read (we=0, no error): o_wb_dat loads i_rnd as sampled at the acceptance edge; held constant until the next accepted non-error read.
REQ-025 Write (we=0 excluded, no error): in the RESP cycle, o_signature <= rotate_left_1(o_signature) XOR masked data, where byte k of masked data = latched dat byte k if sel[k] else 8'h00.
REQ-026 Write with sel all zero still acks and still rotates the signature.
REQ-027 Abort: i_wb_cyc low during WAIT -> return to IDLE next edge, no ack/err, no o_wb_dat or signature update.
REQ-028 i_wb_cyc low in the RESP cycle does not suppress the pulse.
REQ-029 i_wb_stb without i_wb_cyc is ignored.
REQ-030 Changes on master inputs after acceptance have no effect on the in-flight transaction.

Reset
REQ-031 reset high asynchronously forces state IDLE, counter 0, o_wb_ack 0, o_wb_err 0, o_wb_dat 0, o_signature 0, o_busy 0.
REQ-032 Reset asserted mid-transaction discards it; no response pulse after deassertion.
REQ-033 First request is sampled at the first rising edge with reset low.

Verification
REQ-034 WAIT_CYCLES=2, read at 0x0000_0100, i_rnd=0xA5..A5 at edge N -> o_wb_ack high only in cycle after edge N+3, o_wb_dat=0xA5..A5; busy high 3 cycles.
REQ-035 Write dat=0x0123..EF, sel=16'h00FF, signature 0 -> ack; o_signature = low 8 bytes of dat, high 8 bytes 0.
REQ-036 Read at 0xF000_0000 -> o_wb_err one pulse, o_wb_ack never high, o_wb_dat and o_signature unchanged.
REQ-037 i_wb_cyc dropped one cycle after acceptance -> no ack/err, back to IDLE, next read completes normally with new i_rnd value.
REQ-038 reset asserted between clock edges during WAIT -> outputs zero immediately; no pulse after release.
REQ-039 WAIT_CYCLES=0, cyc/stb held high continuously -> ack pulses every 2 cycles, never on consecutive cycles.

Source files
------------

// File: rtl/amber_wb_responder.sv
// Wishbone slave responder: accepts one request at a time, waits a fixed
// number of cycles, then terminates it with a single ack or err pulse.
// Reads return a random word captured at acceptance. Writes fold the
// byte-masked write data into a rotating signature register.
//
// Handshake: a request is taken when i_wb_cyc & i_wb_stb are high at a
// rising edge while the responder is idle. Everything the master drives is
// latched at that edge. The transaction ends with exactly one
// o_wb_ack/o_wb_err pulse one cycle long. If i_wb_cyc drops while the
// responder is waiting, the transaction is abandoned without a pulse.
module amber_wb_responder #(
    parameter int          DATA_W      = 128,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] ERR_BASE    = 32'hF000_0000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         i_wb_adr,
    input  logic [DATA_W/8-1:0] i_wb_sel,
    input  logic                i_wb_we,
    input  logic [DATA_W-1:0]   i_wb_dat,
    input  logic                i_wb_cyc,
    input  logic                i_wb_stb,
    input  logic [DATA_W-1:0]   i_rnd,
    output logic [DATA_W-1:0]   o_wb_dat,
    output logic                o_wb_ack,
    output logic                o_wb_err,
    output logic [DATA_W-1:0]   o_signature,
    output logic                o_busy,
    output logic [1:0]          o_dbg_state
);

    localparam int SEL_W = DATA_W / 8;
    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [31:0]         adr_q, adr_d;
    logic                we_q, we_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [DATA_W-1:0]   dat_q, dat_d;
    logic [DATA_W-1:0]   rnd_q, rnd_d;
    logic                ack_q, ack_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   rdat_q, rdat_d;
    logic [DATA_W-1:0]   sig_q, sig_d;
    logic [DATA_W-1:0]   masked;

    // Write data with unselected byte lanes forced to zero.
    always_comb begin
        masked = '0;
        for (int k = 0; k < SEL_W; k++) begin
            masked[k*8 +: 8] = sel_q[k] ? dat_q[k*8 +: 8] : 8'h00;
        end
    end

    // Next-state and response logic; RESP never samples the bus, which
    // guarantees an idle cycle between consecutive responses.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        adr_d   = adr_q;
        we_d    = we_q;
        sel_d   = sel_q;
        dat_d   = dat_q;
        rnd_d   = rnd_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        rdat_d  = rdat_q;
        sig_d   = sig_q;
        case (state_q)
            ST_IDLE: begin
                if (i_wb_cyc && i_wb_stb) begin
                    adr_d   = i_wb_adr;
                    we_d    = i_wb_we;
                    sel_d   = i_wb_sel;
                    dat_d   = i_wb_dat;
                    rnd_d   = i_rnd;
                    cnt_d   = WAIT_CYCLES[CNT_W-1:0];
                    state_d = (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;
                end
            end
            ST_WAIT: begin
                if (!i_wb_cyc) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                if (adr_q >= ERR_BASE) begin
                    err_d = 1'b1;
                end else begin
                    ack_d = 1'b1;
                    if (we_q) begin
                        sig_d = {sig_q[DATA_W-2:0], sig_q[DATA_W-1]} ^ masked;
                    end else begin
                        rdat_d = rnd_q;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; reset discards any in-flight transaction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            adr_q   <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            dat_q   <= '0;
            rnd_q   <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdat_q  <= '0;
            sig_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            adr_q   <= adr_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            dat_q   <= dat_d;
            rnd_q   <= rnd_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rdat_q  <= rdat_d;
            sig_q   <= sig_d;
        end
    end

    assign o_wb_dat    = rdat_q;
    assign o_wb_ack    = ack_q;
    assign o_wb_err    = err_q;
    assign o_signature = sig_q;
    assign o_busy      = (state_q != ST_IDLE);
    assign o_dbg_state = state_q;

endmodule

// File: tb/tb_amber_wb_responder.sv
// Bench for amber_wb_responder: a transaction-level reference model checked
// every cycle, directed scenarios with literal expectations, a randomized
// phase, and a second instance with no wait states.
module tb_amber_wb_responder;

    localparam int          DW       = 128;
    localparam int          SW       = DW / 8;
    localparam int          WAITS    = 2;
    localparam logic [31:0] ERR_BASE = 32'hF000_0000;

    logic          clk;
    logic          rst;
    logic [31:0]   wb_adr;
    logic [SW-1:0] wb_sel;
    logic          wb_we;
    logic [DW-1:0] wb_dat;
    logic          wb_cyc;
    logic          wb_stb;
    logic [DW-1:0] rnd;
    logic [DW-1:0] o_dat;
    logic          o_ack;
    logic          o_err;
    logic [DW-1:0] o_sig;
    logic          o_busy;
    logic [1:0]    o_state;

    logic [DW-1:0] z_dat;
    logic          z_ack;
    logic          z_err;
    logic [DW-1:0] z_sig;
    logic          z_busy;
    logic [1:0]    z_state;

    int n_checks;
    int n_fail;
    bit chk_en;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    amber_wb_responder #(.DATA_W(DW), .WAIT_CYCLES(WAITS), .ERR_BASE(ERR_BASE)) dut (
        .clk(clk), .reset(rst), .i_wb_adr(wb_adr), .i_wb_sel(wb_sel), .i_wb_we(wb_we),
        .i_wb_dat(wb_dat), .i_wb_cyc(wb_cyc), .i_wb_stb(wb_stb), .i_rnd(rnd),
        .o_wb_dat(o_dat), .o_wb_ack(o_ack), .o_wb_err(o_err), .o_signature(o_sig),
        .o_busy(o_busy), .o_dbg_state(o_state)
    );

    // Zero-wait instance with the master requesting reads back to back.
    amber_wb_responder #(.DATA_W(DW), .WAIT_CYCLES(0), .ERR_BASE(ERR_BASE)) dut0 (
        .clk(clk), .reset(rst), .i_wb_adr(32'h0000_0040), .i_wb_sel({SW{1'b1}}), .i_wb_we(1'b0),
        .i_wb_dat('0), .i_wb_cyc(1'b1), .i_wb_stb(1'b1), .i_rnd(rnd),
        .o_wb_dat(z_dat), .o_wb_ack(z_ack), .o_wb_err(z_err), .o_signature(z_sig),
        .o_busy(z_busy), .o_dbg_state(z_state)
    );

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [DW-1:0] mask_bytes(input logic [DW-1:0] d, input logic [SW-1:0] s);
        logic [DW-1:0] m;
        m = '0;
        for (int i = 0; i < SW; i++) begin
            if (s[i]) m[i*8 +: 8] = d[i*8 +: 8];
        end
        return m;
    endfunction

    // ---------------- reference model ----------------
    // One outstanding transaction at most, tracked by the edge index on which
    // it must be answered.
    int            cyc_cnt;
    bit            m_pend;
    int            m_resp;
    logic [31:0]   m_adr;
    logic          m_we;
    logic [SW-1:0] m_sel;
    logic [DW-1:0] m_wdat;
    logic [DW-1:0] m_rnd;
    logic          m_ack, m_err, m_busy;
    logic [DW-1:0] m_dat, m_sig;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pend = 1'b0;
            m_ack  = 1'b0;
            m_err  = 1'b0;
            m_dat  = '0;
            m_sig  = '0;
        end else begin
            cyc_cnt++;
            m_ack = 1'b0;
            m_err = 1'b0;
            if (m_pend) begin
                if (cyc_cnt == m_resp) begin
                    m_pend = 1'b0;
                    if (m_adr >= ERR_BASE) begin
                        m_err = 1'b1;
                    end else begin
                        m_ack = 1'b1;
                        if (m_we) m_sig = ((m_sig << 1) | (m_sig >> (DW - 1))) ^ mask_bytes(m_wdat, m_sel);
                        else      m_dat = m_rnd;
                    end
                end else if (!wb_cyc) begin
                    m_pend = 1'b0;
                end
            end else if (wb_cyc && wb_stb) begin
                m_pend = 1'b1;
                m_resp = cyc_cnt + 1 + WAITS;
                m_adr  = wb_adr;
                m_we   = wb_we;
                m_sel  = wb_sel;
                m_wdat = wb_dat;
                m_rnd  = rnd;
            end
        end
        m_busy = m_pend;
    end

    // ---------------- scoreboard compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            check("ack", {127'd0, o_ack}, {127'd0, m_ack});
            check("err", {127'd0, o_err}, {127'd0, m_err});
            check("busy", {127'd0, o_busy}, {127'd0, m_busy});
            check("rdata", o_dat, m_dat);
            check("signature", o_sig, m_sig);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(negedge clk);
        rnd = rand_word();
    endtask

    task automatic req(input logic we, input logic [31:0] adr, input logic [SW-1:0] sel,
                       input logic [DW-1:0] dat);
        wb_cyc = 1'b1;
        wb_stb = 1'b1;
        wb_we  = we;
        wb_adr = adr;
        wb_sel = sel;
        wb_dat = dat;
    endtask

    task automatic release_bus();
        wb_cyc = 1'b0;
        wb_stb = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    localparam logic [DW-1:0] PAT_A5 = {16{8'hA5}};
    localparam logic [DW-1:0] PAT_5A = {16{8'h5A}};
    localparam logic [DW-1:0] WDATA  = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [DW-1:0] SIG1   = 128'h0000000000000000_0123456789ABCDEF;

    initial begin
        int   z_cnt;
        logic z_prev;
        n_checks = 0;
        n_fail   = 0;
        chk_en   = 1'b0;
        cyc_cnt  = 0;
        rst      = 1'b1;
        wb_adr   = '0;
        wb_sel   = '0;
        wb_we    = 1'b0;
        wb_dat   = '0;
        wb_cyc   = 1'b0;
        wb_stb   = 1'b0;
        rnd      = '0;

        repeat (3) step();
        chk_en = 1'b1;
        check("reset_ack", {127'd0, o_ack}, '0);
        check("reset_sig", o_sig, '0);
        rst = 1'b0;

        // Read with wait states: busy three cycles, ack on the fourth.
        step();
        req(1'b0, 32'h0000_0100, {SW{1'b1}}, rand_word());
        rnd = PAT_A5;
        step(); wb_stb = 1'b0;
        check("rd_busy_1", {127'd0, o_busy}, 128'd1);
        step();
        check("rd_busy_2", {127'd0, o_busy}, 128'd1);
        step();
        check("rd_busy_3", {127'd0, o_busy}, 128'd1);
        check("rd_no_early_ack", {127'd0, o_ack}, '0);
        step();
        check("rd_ack", {127'd0, o_ack}, 128'd1);
        check("rd_data", o_dat, PAT_A5);
        check("rd_idle", {127'd0, o_busy}, '0);
        release_bus();
        step();
        check("rd_ack_one_cycle", {127'd0, o_ack}, '0);

        // Write with only the low eight lanes selected.
        req(1'b1, 32'h0000_0200, 16'h00FF, WDATA);
        step(); wb_stb = 1'b0; wb_dat = rand_word();
        repeat (2) step();
        step();
        check("wr_ack", {127'd0, o_ack}, 128'd1);
        check("wr_sig", o_sig, SIG1);
        release_bus();
        step();

        // Read of the error region: err pulse, data and signature untouched.
        req(1'b0, 32'hF000_0000, {SW{1'b1}}, '0);
        step(); wb_stb = 1'b0;
        repeat (2) step();
        step();
        check("err_pulse", {127'd0, o_err}, 128'd1);
        check("err_no_ack", {127'd0, o_ack}, '0);
        check("err_dat_kept", o_dat, PAT_A5);
        check("err_sig_kept", o_sig, SIG1);
        release_bus();
        step();

        // Abort one cycle after acceptance, then a normal read.
        req(1'b0, 32'h0000_0300, {SW{1'b1}}, '0);
        step(); release_bus();
        step();
        check("abort_idle", {127'd0, o_busy}, '0);
        repeat (3) step();
        req(1'b0, 32'h0000_0304, {SW{1'b1}}, '0);
        rnd = PAT_5A;
        step(); wb_stb = 1'b0;
        repeat (3) step();
        check("post_abort_ack", {127'd0, o_ack}, 128'd1);
        check("post_abort_data", o_dat, PAT_5A);
        release_bus();

        // Randomized traffic, including aborts and error-region accesses.
        for (int i = 0; i < 400; i++) begin
            step();
            wb_cyc = ($urandom_range(0, 9) != 0);
            wb_stb = ($urandom_range(0, 3) != 0);
            wb_we  = $urandom_range(0, 1);
            wb_adr = ($urandom_range(0, 3) == 0) ? (ERR_BASE | 32'($urandom_range(0, 255)))
                                                 : 32'($urandom_range(0, 32'h7FFF_FFFF));
            wb_sel = ($urandom_range(0, 7) == 0) ? '0 : SW'($urandom);
            wb_dat = rand_word();
        end
        step();
        release_bus();
        repeat (5) step();

        // Reset between edges while waiting: outputs clear at once, no pulse later.
        req(1'b0, 32'h0000_0400, {SW{1'b1}}, '0);
        step(); wb_stb = 1'b0;
        #3 rst = 1'b1;
        #1;
        check("async_rst_busy", {127'd0, o_busy}, '0);
        check("async_rst_dat", o_dat, '0);
        check("async_rst_sig", o_sig, '0);
        check("async_rst_ack", {126'd0, o_err, o_ack}, '0);
        repeat (2) step();
        rst = 1'b0;
        repeat (5) step();
        check("no_pulse_after_rst", {126'd0, o_err, o_ack}, '0);
        release_bus();

        // Zero-wait instance: acks alternate with idle cycles.
        step();
        z_prev = z_ack;
        z_cnt  = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            check("w0_alternate", {127'd0, z_ack}, {127'd0, ~z_prev});
            check("w0_no_err", {127'd0, z_err}, '0);
            z_prev = z_ack;
            if (z_ack) z_cnt++;
        end
        check("w0_ack_count", 128'(z_cnt), 128'd10);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
